divisor_clock: RTL and testbench

//   Programmable clock divider. Derives a slow, glitch-free square wave
//   (Clk_out) from the board clock (Clk_in); one Clk_out period = Overflow
//   Clk_in cycles. Also emits a one-cycle Tick at each period wrap.

---
 rtl/divisor_clock.sv | 51 +++++
 tb/tb_divisor_clock.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divisor_clock.sv
// Programmable clock divider: a registered square wave with a period of Overflow
// input cycles, plus a one-cycle Tick at each period wrap.
module divisor_clock #(
  parameter int unsigned WIDTH = 23
) (
  input  logic             Clk_in,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Overflow,
  output logic             Clk_out,
  output logic             Tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] low_len;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             enable;
  logic             at_end;

  always_comb begin
    enable    = (Overflow > WIDTH'(1));
    // Ceiling of half the period, so an odd period gives the extra cycle to the low phase.
    low_len   = Overflow - (Overflow >> 1);
    at_end    = (cnt_q >= (Overflow - WIDTH'(1)));
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (enable) begin
      // A shrunk period catches a count already past its end and wraps it at once.
      cnt_d     = at_end ? '0 : cnt_q + WIDTH'(1);
      clk_out_d = (cnt_d >= low_len);
      tick_d    = (cnt_d == '0) && (cnt_q != '0);
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign Clk_out = clk_out_q;
  assign Tick    = tick_q;

endmodule

// File: tb/tb_divisor_clock.sv
// Bench for divisor_clock: directed scenarios plus randomized periods, every edge checked
// against a phase-position model of the divided clock.
module tb_divisor_clock;

  localparam int unsigned W = 23;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ovf = '0;
  logic         clk_out;
  logic         tick;

  int total = 0;
  int bad   = 0;

  // Model: position within the current period and the outputs it implies.
  longint m_pos  = 0;
  bit     m_clk  = 1'b0;
  bit     m_tick = 1'b0;

  divisor_clock #(.WIDTH(W)) dut (
    .Clk_in  (clk),
    .Rst     (rst),
    .Overflow(ovf),
    .Clk_out (clk_out),
    .Tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    longint old_pos, per;
    @(posedge clk);
    per = longint'(ovf);
    if (rst) begin
      m_pos = 0; m_clk = 1'b0; m_tick = 1'b0;
    end else if (per < 2) begin
      m_pos = 0; m_clk = 1'b0; m_tick = 1'b0;
    end else begin
      old_pos = m_pos;
      m_pos   = (old_pos >= per) ? 0 : (old_pos + 1) % per;
      m_clk   = (2 * m_pos >= per);
      m_tick  = (m_pos == 0) && (old_pos != 0);
    end
    #1;
    chk({tag, ".clk"}, clk_out, m_clk);
    chk({tag, ".tick"}, tick, m_tick);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step("reset");
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset then period 10
    ovf = W'(10);
    do_reset(2);
    chk("reset_clk", clk_out, 1'b0);
    chk("reset_tick", tick, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      step("p10");
      chk("p10_edge_clk", clk_out, (k % 10) >= 5);
      chk("p10_edge_tick", tick, (k % 10) == 0);
    end

    // 2: odd period 5, then period 2
    ovf = W'(5);
    do_reset(1);
    for (int k = 1; k <= 20; k++) begin
      step("p5");
      chk("p5_edge_clk", clk_out, (k % 5) >= 3);
      chk("p5_edge_tick", tick, (k % 5) == 0);
    end
    ovf = W'(2);
    do_reset(1);
    for (int k = 1; k <= 10; k++) begin
      step("p2");
      chk("p2_toggle", clk_out, k[0]);
    end

    // 3: disabled periods, then period 4 rises at edge 2
    ovf = W'(0);
    for (int k = 0; k < 25; k++) step("ovf0");
    ovf = W'(1);
    for (int k = 0; k < 25; k++) step("ovf1");
    ovf = W'(4);
    step("p4_e1");
    chk("p4_e1_low", clk_out, 1'b0);
    step("p4_e2");
    chk("p4_e2_rise", clk_out, 1'b1);

    // 4: shrink period from 100 to 10 while high
    ovf = W'(100);
    do_reset(1);
    for (int k = 0; k < 50; k++) step("p100");
    chk("p100_high", clk_out, 1'b1);
    ovf = W'(10);
    step("shrink");
    chk("shrink_clk", clk_out, 1'b0);
    chk("shrink_tick", tick, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step("after_shrink");
      chk("after_shrink_clk", clk_out, (k % 10) >= 5);
    end

    // 5: reset while high
    for (int k = 0; k < 6; k++) step("pre_rst");
    chk("pre_rst_high", clk_out, 1'b1);
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_clk", clk_out, 1'b0);
    chk("mid_rst_tick", tick, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step("post_rst");
      chk("post_rst_rise", clk_out, k == 5);
    end

    // 6: large periods, leading low phase only
    ovf = W'(5_000_000);
    do_reset(1);
    for (int k = 0; k < 1000; k++) step("p5m");
    ovf = W'(8_388_607);
    for (int k = 0; k < 1000; k++) step("pmax");
    chk("pmax_low", clk_out, 1'b0);

    // Randomized periods, mid-period changes and reset pulses
    ovf = W'(7);
    do_reset(1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) ovf = W'($urandom_range(0, 40));
      rst = ($urandom_range(0, 19) == 0);
      for (int k = 0, n = $urandom_range(1, 25); k < n; k++) step("rand");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
